// File: rtl/cpu_pkg.sv
// Shared CPU-side types and sizes for the data-memory arbiter.
package cpu_pkg;

   localparam int DATA_W           = 8;
   localparam int ADDR_W           = 8;
   localparam int DEF_STARVE_LIMIT = 4;
   localparam int DEF_STALL_BEATS  = 2;

   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } arb_state_t;

endpackage

// File: rtl/dmem_port_mux.sv
// Combinational steering of the single data-memory port between CPU and DMA.
module dmem_port_mux
   import cpu_pkg::*;
(
   input  logic              dma_gnt,
   input  logic              cpu_mask,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   input  logic              dma_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we
);

   assign mem_addr  = dma_gnt ? dma_addr  : cpu_addr;
   assign mem_wdata = dma_gnt ? dma_wdata : cpu_wdata;
   // A frozen CPU store must not land while stalled; it is replayed after FORCE.
   assign mem_we    = dma_gnt ? dma_we    : (cpu_wr & ~cpu_mask);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU priority, with a starvation counter that freezes
// the pipeline so the DMA requester is guaranteed forward progress.
module dmem_arbiter
   import cpu_pkg::*;
#(
   parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
   parameter int STALL_BEATS  = DEF_STALL_BEATS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_rd,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dma_valid,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_ready,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              pipe_stall
);

   localparam logic [3:0] WAIT_LAST = 4'(STARVE_LIMIT - 1);
   localparam logic [3:0] BEAT_LAST = 4'(STALL_BEATS - 1);

   arb_state_t state;
   logic [3:0] wait_cnt;
   logic [3:0] beat_cnt;
   logic       cpu_busy;
   logic       dma_gnt;
   logic       beat_acc;

   assign cpu_busy   = cpu_rd | cpu_wr;
   assign dma_gnt    = dma_valid & ((state == FORCE) | ~cpu_busy);
   assign dma_ready  = dma_gnt;
   assign beat_acc   = dma_valid & dma_gnt;
   assign cpu_rdata  = mem_rdata;
   assign pipe_stall = (state == FORCE);

   dmem_port_mux u_mux (
      .dma_gnt   (dma_gnt),
      .cpu_mask  (state == FORCE),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_wr    (cpu_wr),
      .dma_addr  (dma_addr),
      .dma_wdata (dma_wdata),
      .dma_we    (dma_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_we    (mem_we)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= NORMAL;
         wait_cnt   <= '0;
         beat_cnt   <= '0;
         dma_rvalid <= 1'b0;
         dma_rdata  <= '0;
      end else begin
         dma_rvalid <= beat_acc & ~dma_we;
         if (beat_acc && !dma_we) dma_rdata <= mem_rdata;

         case (state)
            NORMAL: begin
               if (dma_valid && cpu_busy) begin
                  if (wait_cnt == WAIT_LAST) begin
                     state    <= FORCE;
                     wait_cnt <= '0;
                     beat_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt + 4'd1;
                  end
               end else begin
                  wait_cnt <= '0;
               end
            end
            FORCE: begin
               wait_cnt <= '0;
               // Leave on the last beat of the window, or as soon as the DMA goes idle.
               if (beat_acc && beat_cnt != BEAT_LAST) begin
                  beat_cnt <= beat_cnt + 4'd1;
               end else begin
                  state    <= NORMAL;
                  beat_cnt <= '0;
               end
            end
            default: begin
               state    <= NORMAL;
               wait_cnt <= '0;
               beat_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: default-parameter instance driven from a
// vector table plus hand sequences, and a STARVE_LIMIT=1/STALL_BEATS=1 instance.
module tb_dmem_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cpu_rd = 1'b0, cpu_wr = 1'b0;
   logic [7:0] cpu_addr = 8'h00, cpu_wdata = 8'h00;
   logic       dma_valid = 1'b0, dma_we = 1'b0;
   logic [7:0] dma_addr = 8'h00, dma_wdata = 8'h00;

   logic [7:0] m0_addr, m0_wdata, m0_rdata, c0_rdata, d0_rdata;
   logic       m0_we, d0_ready, d0_rvalid, s0;
   logic [7:0] m1_addr, m1_wdata, m1_rdata, c1_rdata, d1_rdata;
   logic       m1_we, d1_ready, d1_rvalid, s1;

   logic [7:0] mem0 [256];
   logic [7:0] mem1 [256];

   int nchk = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   assign m0_rdata = mem0[m0_addr];
   assign m1_rdata = mem1[m1_addr];
   always @(posedge clk) if (m0_we) mem0[m0_addr] <= m0_wdata;
   always @(posedge clk) if (m1_we) mem1[m1_addr] <= m1_wdata;

   dmem_arbiter u0 (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(c0_rdata),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ready(d0_ready), .dma_rvalid(d0_rvalid), .dma_rdata(d0_rdata),
      .mem_addr(m0_addr), .mem_we(m0_we), .mem_wdata(m0_wdata), .mem_rdata(m0_rdata),
      .pipe_stall(s0)
   );

   dmem_arbiter #(.STARVE_LIMIT(1), .STALL_BEATS(1)) u1 (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(c1_rdata),
      .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_ready(d1_ready), .dma_rvalid(d1_rvalid), .dma_rdata(d1_rdata),
      .mem_addr(m1_addr), .mem_we(m1_we), .mem_wdata(m1_wdata), .mem_rdata(m1_rdata),
      .pipe_stall(s1)
   );

   typedef struct {
      logic       crd, cwr;
      logic [7:0] caddr, cwdata;
      logic       dv, dwe;
      logic [7:0] daddr, dwdata;
      logic       e_ready, e_stall, e_we;
      logic [7:0] e_addr, e_wdata;
      logic       e_rvalid;
      logic [7:0] e_rdata;
   } vec_t;

   vec_t vecs [19];

   function automatic vec_t mk(input logic crd, input logic cwr, input logic [7:0] caddr,
                               input logic [7:0] cwdata, input logic dv, input logic dwe,
                               input logic [7:0] daddr, input logic [7:0] dwdata,
                               input logic e_ready, input logic e_stall, input logic e_we,
                               input logic [7:0] e_addr, input logic [7:0] e_wdata,
                               input logic e_rvalid, input logic [7:0] e_rdata);
      vec_t v;
      v.crd = crd;  v.cwr = cwr;  v.caddr = caddr;  v.cwdata = cwdata;
      v.dv = dv;    v.dwe = dwe;  v.daddr = daddr;  v.dwdata = dwdata;
      v.e_ready = e_ready; v.e_stall = e_stall; v.e_we = e_we;
      v.e_addr = e_addr;   v.e_wdata = e_wdata;
      v.e_rvalid = e_rvalid; v.e_rdata = e_rdata;
      return v;
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0b want %0b", name, act, exp);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %02h want %02h", name, act, exp);
      end
   endtask

   task automatic drive(input logic crd, input logic cwr, input logic [7:0] caddr,
                        input logic [7:0] cwdata, input logic dv, input logic dwe,
                        input logic [7:0] daddr, input logic [7:0] dwdata);
      cpu_rd = crd; cpu_wr = cwr; cpu_addr = caddr; cpu_wdata = cwdata;
      dma_valid = dv; dma_we = dwe; dma_addr = daddr; dma_wdata = dwdata;
   endtask

   initial begin
      int k;
      // idle CPU: DMA write then read back
      vecs[0]  = mk(0,0,8'h00,8'h00, 1,1,8'h10,8'h5A,  1,0,1,8'h10,8'h5A, 0,8'h00);
      vecs[1]  = mk(0,0,8'h00,8'h00, 1,0,8'h10,8'h00,  1,0,0,8'h10,8'h00, 0,8'h00);
      vecs[2]  = mk(0,0,8'h00,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h00,8'h00, 1,8'h5A);
      // persistent conflict: 4 blocked cycles, 2-beat FORCE window, CPU replay
      for (int i = 3; i <= 6; i++)
         vecs[i] = mk(0,1,8'h20,8'h33, 1,1,8'h30,8'hA1, 0,0,1,8'h20,8'h33, 0,8'h00);
      vecs[7]  = mk(0,1,8'h20,8'h33, 1,1,8'h30,8'hA1,  1,1,1,8'h30,8'hA1, 0,8'h00);
      vecs[8]  = mk(0,1,8'h20,8'h33, 1,1,8'h31,8'hA2,  1,1,1,8'h31,8'hA2, 0,8'h00);
      vecs[9]  = mk(0,1,8'h20,8'h33, 0,0,8'h00,8'h00,  0,0,1,8'h20,8'h33, 0,8'h00);
      // conflict where the DMA goes idle after one FORCE beat
      for (int i = 10; i <= 13; i++)
         vecs[i] = mk(0,1,8'h21,8'h44, 1,1,8'h32,8'hB1, 0,0,1,8'h21,8'h44, 0,8'h00);
      vecs[14] = mk(0,1,8'h21,8'h44, 1,1,8'h32,8'hB1,  1,1,1,8'h32,8'hB1, 0,8'h00);
      vecs[15] = mk(0,1,8'h21,8'h44, 0,0,8'h00,8'h00,  0,1,0,8'h21,8'h44, 0,8'h00);
      vecs[16] = mk(0,1,8'h21,8'h44, 0,0,8'h00,8'h00,  0,0,1,8'h21,8'h44, 0,8'h00);
      // same-address collision: CPU wins
      vecs[17] = mk(0,1,8'h40,8'h55, 1,1,8'h40,8'h66,  0,0,1,8'h40,8'h55, 0,8'h00);
      vecs[18] = mk(1,0,8'h40,8'h00, 0,0,8'h00,8'h00,  0,0,0,8'h40,8'h00, 0,8'h00);

      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk1("reset_stall", s0, 1'b0);
      chk1("reset_rvalid", d0_rvalid, 1'b0);
      chk8("reset_rdata", d0_rdata, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 19; i++) begin
         if (i > 0) @(negedge clk);
         drive(vecs[i].crd, vecs[i].cwr, vecs[i].caddr, vecs[i].cwdata,
               vecs[i].dv, vecs[i].dwe, vecs[i].daddr, vecs[i].dwdata);
         #1;
         chk1($sformatf("v%0d_ready", i), d0_ready, vecs[i].e_ready);
         chk1($sformatf("v%0d_stall", i), s0, vecs[i].e_stall);
         chk1($sformatf("v%0d_mem_we", i), m0_we, vecs[i].e_we);
         chk8($sformatf("v%0d_mem_addr", i), m0_addr, vecs[i].e_addr);
         chk8($sformatf("v%0d_mem_wdata", i), m0_wdata, vecs[i].e_wdata);
         chk1($sformatf("v%0d_rvalid", i), d0_rvalid, vecs[i].e_rvalid);
         if (vecs[i].e_rvalid) chk8($sformatf("v%0d_rdata", i), d0_rdata, vecs[i].e_rdata);
         if (i == 16) chk8("wait_cnt_after_idle_exit", 8'(u0.wait_cnt), 8'h00);
      end
      chk8("cpu_rdata_0x40", c0_rdata, 8'h55);
      chk8("mem_0x10", mem0[8'h10], 8'h5A);
      chk8("mem_0x20", mem0[8'h20], 8'h33);
      chk8("mem_0x30", mem0[8'h30], 8'hA1);
      chk8("mem_0x31", mem0[8'h31], 8'hA2);
      chk8("mem_0x21", mem0[8'h21], 8'h44);
      chk8("mem_0x40", mem0[8'h40], 8'h55);

      // asynchronous reset arriving inside a FORCE window
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         drive(0,1,8'h22,8'h77, 1,0,8'h10,8'h00);
         #1;
         chk1($sformatf("rst_seq_block%0d", i), d0_ready, 1'b0);
      end
      @(negedge clk);
      #1;
      chk1("rst_seq_force_stall", s0, 1'b1);
      chk1("rst_seq_force_ready", d0_ready, 1'b1);
      chk1("rst_seq_cpu_masked", m0_we, 1'b0);
      @(posedge clk);
      #2;
      chk1("rst_seq_pre_rvalid", d0_rvalid, 1'b1);
      chk8("rst_seq_pre_rdata", d0_rdata, 8'h5A);
      chk1("rst_seq_pre_stall", s0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("rst_async_stall", s0, 1'b0);
      chk1("rst_async_rvalid", d0_rvalid, 1'b0);
      chk8("rst_async_rdata", d0_rdata, 8'h00);
      chk8("rst_async_wait_cnt", 8'(u0.wait_cnt), 8'h00);
      chk8("rst_async_beat_cnt", 8'(u0.beat_cnt), 8'h00);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      drive(0,0,8'h00,8'h00, 1,1,8'h50,8'hC3);
      #1;
      chk1("rst_replay_ready", d0_ready, 1'b1);
      @(negedge clk);
      drive(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
      #1;
      chk8("rst_replay_mem_0x50", mem0[8'h50], 8'hC3);

      // STARVE_LIMIT=1, STALL_BEATS=1: stall alternates with one beat per stall cycle
      @(negedge clk);
      rst_n = 1'b0;
      drive(0,1,8'h70,8'h11, 1,1,8'h60,8'hD0);
      @(negedge clk);
      rst_n = 1'b1;
      k = 0;
      for (int i = 0; i < 6; i++) begin
         dma_addr  = 8'h60 + 8'(k);
         dma_wdata = 8'hD0 + 8'(k);
         #1;
         chk1($sformatf("lim1_stall%0d", i), s1, 1'(i % 2));
         chk1($sformatf("lim1_ready%0d", i), d1_ready, 1'(i % 2));
         if (i % 2 == 1) k++;
         @(negedge clk);
      end
      drive(0,0,8'h00,8'h00, 0,0,8'h00,8'h00);
      #1;
      chk8("lim1_mem_0x60", mem1[8'h60], 8'hD0);
      chk8("lim1_mem_0x61", mem1[8'h61], 8'hD1);
      chk8("lim1_mem_0x62", mem1[8'h62], 8'hD2);
      chk8("lim1_mem_0x70", mem1[8'h70], 8'h11);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single 8-bit data-memory port between the CPU pipeline MEM stage and a DMA/debug requester that uses a valid/ready handshake.
- The CPU has default priority.
- A starvation counter guarantees DMA progress by freezing the whole pipeline for a bounded number of cycles.
- The block sits between the MEM stage, the DMA port and the data memory, and sources the global pipeline-freeze signal.

Parameters:
- STARVE_LIMIT, 4: consecutive blocked DMA cycles before a forced pipeline stall (legal range 1..15).
- STALL_BEATS, 2: maximum number of DMA beats served per forced stall window (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_rd  in  1  MEM-stage read request (MEMread).
- cpu_wr  in  1  MEM-stage write request (MEMwr).
- cpu_addr  in  8  MEM-stage address (ALU result).
- cpu_wdata  in  8  MEM-stage store data.
- cpu_rdata  out  8  load data to the MEM/WB register; equals mem_rdata.
- dma_valid  in  1  DMA beat present.
- dma_we  in  1  1 = write beat, 0 = read beat.
- dma_addr  in  8  DMA address.
- dma_wdata  in  8  DMA write data.
- dma_ready  out  1  beat accepted this cycle (combinational).
- dma_rvalid  out  1  read data valid, registered.
- dma_rdata  out  8  read data, registered.
- mem_addr  out  8  memory address.
- mem_we  out  1  memory write strobe.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory combinational read data.
- pipe_stall  out  1  freeze the PC and all pipeline registers, registered.

Behaviour:
- Memory model: combinational read, write on the rising clk edge when mem_we=1.
- States: NORMAL, FORCE.
- Registered counters: wait_cnt[3:0] and beat_cnt[3:0].
- Reset values: state=NORMAL, wait_cnt=0, beat_cnt=0, pipe_stall=0, dma_rvalid=0, dma_rdata=0.
- Reset is asynchronous and may arrive mid-transfer. Any beat not yet accepted is dropped; the DMA keeps dma_valid high and re-presents it.
- cpu_busy = cpu_rd | cpu_wr.
- dma_gnt:
  - (state==FORCE && dma_valid), or
  - (state==NORMAL && dma_valid && !cpu_busy).
- dma_ready = dma_gnt. A beat completes when dma_valid && dma_ready.
- Port mux:
  - dma_gnt=1: mem_addr=dma_addr, mem_wdata=dma_wdata, mem_we=dma_we.
  - Otherwise: cpu_addr, cpu_wdata, cpu_wr.
  - In FORCE the CPU request is masked; mem_we is never sourced from cpu_wr.
- pipe_stall = (state==FORCE), taken directly from the state flop.
- The frozen MEM-stage access is replayed unchanged in the first NORMAL cycle after FORCE.
- Read return: on an accepted read beat, dma_rdata <= mem_rdata and dma_rvalid <= 1 at the next edge. Otherwise dma_rvalid <= 0. Latency is exactly one cycle.
- NORMAL transitions:
  - dma_valid && cpu_busy: wait_cnt increments.
    - If wait_cnt == STARVE_LIMIT-1, go to FORCE, clear wait_cnt, clear beat_cnt.
    - STARVE_LIMIT=1 enters FORCE after a single blocked cycle.
  - Any DMA grant, or dma_valid=0: clear wait_cnt.
- FORCE transitions:
  - Each accepted beat increments beat_cnt.
  - Return to NORMAL when (accepted beat && beat_cnt == STALL_BEATS-1) or when dma_valid=0. The dma_valid=0 exit costs exactly one stall cycle with no transfer.
  - wait_cnt is held at 0 throughout FORCE.
- pipe_stall is never asserted for more than STALL_BEATS cycles per window.
- After FORCE exits, at least one NORMAL cycle follows before the next FORCE. Because wait_cnt restarts from 0, the minimum gap is STARVE_LIMIT cycles.
- Counters saturate logically: they never wrap, because each is cleared at its limit.

Decomposition:
- Shared package (cpu_pkg):
  - DATA_W=8, ADDR_W=8.
  - Arbiter state enum (NORMAL, FORCE).
  - Default STARVE_LIMIT and STALL_BEATS constants.
- Natural sub-module: dmem_port_mux. It is purely combinational: dma_gnt selects between the CPU and DMA address/data/write fields. The FSM, counters and read-return register stay in dmem_arbiter.

Test Plan:
- Idle CPU, DMA write 0x5A to 0x10 then read 0x10 → dma_ready=1 on both beats with no waits. The cycle after the read, dma_rvalid=1 and dma_rdata=0x5A. pipe_stall stays 0.
- CPU writes 0x33 to 0x20 every cycle while dma_valid is held high (defaults) → dma_ready=0 for 4 cycles. pipe_stall=1 on cycles 5–6 with 2 DMA beats accepted. Cycle 7 is NORMAL with the CPU write replayed, and memory[0x20]=0x33.
- Same conflict, but dma_valid drops after 1 beat inside FORCE → FORCE exits the next cycle. pipe_stall is high for exactly 2 cycles (one with a transfer, one without). wait_cnt=0.
- Simultaneous CPU write and DMA write to 0x40 in NORMAL → the CPU wins, mem_we comes from cpu_wr, and the DMA beat is not accepted.
- rst_n pulsed low mid-FORCE (asynchronous, between clk edges) → pipe_stall, dma_rvalid and the counters go to 0 immediately. After release the DMA re-presents its beat and it completes.
- STARVE_LIMIT=1, STALL_BEATS=1, continuous conflict → the pipe_stall pattern alternates 0,1,0,1 with one DMA beat per stall cycle.
